key_debouncer: RTL
==================

// Module: key_debouncer
// PURPOSE
//  Debounces the DE2-115 push-buttons (KEY[3:0], active-low) in the CLOCK_50 domain, directly downstream of the
//  top-level pins and the per-clock reset. Emits a clean level plus one-cycle press/release/auto-repeat pulses
//  per key for user logic. One shared 1 ms tick drives N independent per-key FSMs.
// PARAMETERS
//  NUM_KEYS        4           number of key channels
//  CLK_HZ          50_000_000  clk frequency; ms tick period = CLK_HZ/1000 cycles (CLK_HZ%1000==0, >=2000)
//  ACTIVE_LOW      1           1: raw key pressed when pin==0; 0: pressed when pin==1
//  DEBOUNCE_MS     10          stable ms ticks required to accept a press or release (>=1)
//  REPEAT_EN       1           1: generate auto-repeat pulses while held; 0: key_repeat tied 0
//  REPEAT_DELAY_MS 500         ms ticks in PRESSED before first repeat pulse (>=1)
//  REPEAT_RATE_MS  100         ms ticks between subsequent repeat pulses (>=1)
// PORTS
//  clk          in   1         CLOCK_50
//  reset_n      in   1         async assert, active-low; deassert synchronous to clk upstream
//  key_raw      in   NUM_KEYS  asynchronous button pins
//  key_level    out  NUM_KEYS  debounced state, 1 = pressed
//  key_press    out  NUM_KEYS  1-cycle pulse on accepted press
//  key_release  out  NUM_KEYS  1-cycle pulse on accepted release
//  key_repeat   out  NUM_KEYS  1-cycle pulse per auto-repeat while held
//  ms_tick      out  1         1-cycle pulse every CLK_HZ/1000 cycles (shared, exported)
// BEHAVIOUR
//  Reset (reset_n=0, async): all outputs 0; tick prescaler 0; all FSMs RELEASED; sync flops = released level.
//  Sync: 2-flop synchronizer per key, polarity-normalised after sync (p = pressed). 2-cycle input latency.
//  Tick: prescaler counts 0..CLK_HZ/1000-1, wraps; ms_tick=1 in the cycle count==CLK_HZ/1000-1.
//  Per-key FSM (cnt counts ms_ticks, zeroed on every state entry):
//   RELEASED     : p -> PRESS_WAIT.
//   PRESS_WAIT   : !p -> RELEASED (bounce, no pulse); p & ms_tick & cnt==DEBOUNCE_MS-1 -> PRESSED,
//                  key_press=1 and key_level=1 registered in that cycle's next edge; else cnt++ on ms_tick.
//   PRESSED      : !p -> RELEASE_WAIT (rpt counter kept); ms_tick -> rpt++; REPEAT_EN and
//                  rpt reaches REPEAT_DELAY_MS, then every REPEAT_RATE_MS further ticks -> key_repeat pulse.
//   RELEASE_WAIT : p -> PRESSED (bounce, no pulse, key_level stays 1); !p & ms_tick & cnt==DEBOUNCE_MS-1
//                  -> RELEASED, key_release=1, key_level=0, rpt cleared.
//  Effective debounce window is DEBOUNCE_MS-1..DEBOUNCE_MS ms (entry is unaligned to tick) -- by design.
//  Pulses registered; press/release/repeat never coincide on one key in one cycle; repeat suppressed in the
//  cycle a release is accepted. Channels fully independent; simultaneous events on several keys all reported.
//  rpt counter saturates-free: after first repeat it reloads to REPEAT_DELAY_MS-REPEAT_RATE_MS schedule
//  (implement as separate phase bit + counter modulo REPEAT_RATE_MS; no wrap artefacts for any hold length).
//  Counter widths: $clog2(max value+1); no arithmetic overflow permitted.
//  reset_n asserted mid-debounce or mid-hold: immediate return to reset state, no pulse emitted on exit.
//  Key held through reset release: treated as fresh press (full DEBOUNCE_MS before key_press).
// STRUCTURE
//  key_debouncer_pkg: typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_e;
//   function cnt_width(int max) for counter sizing.
//  Sub-module key_debounce_channel: synchronizer + FSM + counters for one key, shares ms_tick;
//   top generates NUM_KEYS instances plus the prescaler. Parameter-legality checks via elaboration $error.
// TESTING (bench params: CLK_HZ=10_000 -> ms_tick every 10 cycles, DEBOUNCE_MS=3, REPEAT_DELAY_MS=5,
//          REPEAT_RATE_MS=2, NUM_KEYS=4, ACTIVE_LOW=1)
//  1 Reset: reset_n=0, key_raw=4'hF -> all outputs 0; ms_tick period exactly 10 cycles after release.
//  2 Clean press key0: raw[0]=0 held 60 cycles -> one key_press[0] pulse 3rd tick after sync, key_level[0]=1;
//    no other channel toggles.
//  3 Bounce: raw[0] toggles every 4 cycles for 40 cycles then returns to 1 -> no press/release pulses, level 0.
//  4 Auto-repeat: hold key1 120 ms-ticks-equivalent (1200 cycles) -> key_press at tick 3, first key_repeat 5
//    ticks later, then every 2 ticks; count matches model; release -> one key_release, repeats stop.
//  5 Simultaneous: raw=4'h0 same cycle -> four key_press bits in same cycle; release all -> four key_release.
//  6 Reset mid-hold: key2 PRESSED, reset_n=0 for 3 cycles -> level 0, no release pulse; key still held ->
//    new key_press after full debounce. REPEAT_EN=0 rerun of 4 -> key_repeat never asserts.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// Purpose : shared types and sizing helper for the key debouncer.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package key_debouncer_pkg;

    // Per-key debounce state.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// Purpose : one key: 2-flop synchronizer, debounce FSM, auto-repeat scheduler.
// Latency : 2 cycles sync + DEBOUNCE_MS ms ticks (minus tick alignment) to accepted press/release.
// Backpr. : none; pulses are single-cycle and must be consumed when presented.
// Ports   : i_clk, i_reset_n (async, active-low), i_key_raw (async pin), i_ms_tick (shared 1 ms strobe),
//           o_key_level (debounced, 1 = pressed), o_key_press / o_key_release / o_key_repeat (1-cycle pulses).
module key_debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_key_raw,
    input  logic i_ms_tick,
    output logic o_key_level,
    output logic o_key_press,
    output logic o_key_release,
    output logic o_key_repeat
);

    localparam int DB_W    = cnt_width(DEBOUNCE_MS - 1);
    localparam int RPT_MAX = ((REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS) - 1;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_MS - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_MS - 1);
    // Pin level that means "not pressed"; the synchronizer resets to it so
    // reset release never looks like an edge on an idle key.
    localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             r_sync1, r_sync2;
    key_state_e       r_state, w_state_nxt;
    logic [DB_W-1:0]  r_cnt, w_cnt_nxt;
    logic [RPT_W-1:0] r_rpt, w_rpt_nxt;
    logic             r_phase, w_phase_nxt;   // 0: waiting initial delay, 1: periodic repeats
    logic             r_level, w_level_nxt;
    logic             r_press, w_press_nxt;
    logic             r_release, w_release_nxt;
    logic             r_repeat, w_repeat_nxt;
    logic             w_pressed;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= REL_LVL;
            r_sync2 <= REL_LVL;
        end else begin
            r_sync1 <= i_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_rpt     <= '0;
            r_phase   <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rpt     <= w_rpt_nxt;
            r_phase   <= w_phase_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_repeat  <= w_repeat_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rpt_nxt     = r_rpt;
        w_phase_nxt   = r_phase;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_repeat_nxt  = 1'b0;
        case (r_state)
            RELEASED: begin
                if (w_pressed) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_pressed) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (i_ms_tick) begin
                    if (r_cnt == DB_LAST) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + DB_W'(1);
                    end
                end
            end
            PRESSED: begin
                // Repeat schedule survives a release bounce, so it is only
                // cleared when a release is actually accepted.
                if (!w_pressed) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end else if ((REPEAT_EN != 0) && i_ms_tick) begin
                    if (r_rpt == (r_phase ? RATE_LAST : DELAY_LAST)) begin
                        w_rpt_nxt    = '0;
                        w_phase_nxt  = 1'b1;
                        w_repeat_nxt = 1'b1;
                    end else begin
                        w_rpt_nxt = r_rpt + RPT_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (w_pressed) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (i_ms_tick) begin
                    if (r_cnt == DB_LAST) begin
                        w_state_nxt   = RELEASED;
                        w_cnt_nxt     = '0;
                        w_rpt_nxt     = '0;
                        w_phase_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + DB_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
    end

    assign o_key_level   = r_level;
    assign o_key_press   = r_press;
    assign o_key_release = r_release;
    assign o_key_repeat  = r_repeat;

endmodule

// File: rtl/key_debouncer.sv
// Purpose : debounce NUM_KEYS push-buttons with one shared 1 ms prescaler; level + press/release/repeat pulses.
// Latency : 2 cycles sync + up to DEBOUNCE_MS ms to accepted events; all event outputs registered.
// Backpr. : none; pulses are single-cycle, o_ms_tick is a 1-cycle strobe every CLK_HZ/1000 cycles.
// Ports   : i_clk, i_reset_n (async, active-low), i_key_raw[NUM_KEYS] (async pins),
//           o_key_level / o_key_press / o_key_release / o_key_repeat [NUM_KEYS], o_ms_tick.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int CLK_HZ          = 50_000_000,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [NUM_KEYS-1:0] i_key_raw,
    output logic [NUM_KEYS-1:0] o_key_level,
    output logic [NUM_KEYS-1:0] o_key_press,
    output logic [NUM_KEYS-1:0] o_key_release,
    output logic [NUM_KEYS-1:0] o_key_repeat,
    output logic                o_ms_tick
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int TICK_W   = cnt_width(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    if ((CLK_HZ % 1000) != 0 || CLK_HZ < 2000) begin : g_bad_clk
        $error("key_debouncer: CLK_HZ must be a multiple of 1000 and >= 2000");
    end
    if (NUM_KEYS < 1 || DEBOUNCE_MS < 1 || REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_bad_ms
        $error("key_debouncer: NUM_KEYS and all *_MS parameters must be >= 1");
    end

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_ms_tick;

    assign w_ms_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tick_cnt <= '0;
        end else if (w_ms_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    assign o_ms_tick = w_ms_tick;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_chan (
            .i_clk         (i_clk),
            .i_reset_n     (i_reset_n),
            .i_key_raw     (i_key_raw[g]),
            .i_ms_tick     (w_ms_tick),
            .o_key_level   (o_key_level[g]),
            .o_key_press   (o_key_press[g]),
            .o_key_release (o_key_release[g]),
            .o_key_repeat  (o_key_repeat[g])
        );
    end

endmodule
